// File: rtl/psram_pkg.sv
// Shared PSRAM definitions: bus widths, arbiter state encoding and the
// command opcodes that the arbiter and the PSRAM controller agree on.
package psram_pkg;

    localparam int PSRAM_ADDR_W = 23;
    localparam int PSRAM_CNT_W  = 9;

    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_WRITE     = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER,
        GAP
    } psram_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating priority encoder: the first set request after
// position 'last' (wrapping around) wins.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    // Search positions above 'last' first, then wrap to the lowest set bit.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j] && (j > int'(last))) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j]) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psram_arbiter.sv
// Shares one PSRAM controller between N_REQ burst requesters, round-robin.
// One burst per grant; beats are counted locally and a single idle cycle
// separates bursts so the controller can drop CE#.
// Optional build macro PSRAM_ARB_PRIO0_EN gives requester 0 fixed top priority.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = PSRAM_ADDR_W,
    parameter int CNT_W  = PSRAM_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*CNT_W-1:0]  req_cnt,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        busy,
    output logic [7:0]              rd_data,
    output logic [N_REQ-1:0]        rd_valid,
    input  logic [N_REQ*8-1:0]      wr_data,
    output logic [N_REQ-1:0]        wr_ready,
    output logic                    mem_start_read,
    output logic                    mem_start_write,
    output logic [CNT_W-1:0]        mem_count,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [7:0]              mem_dout,
    input  logic                    mem_r_valid,
    output logic [7:0]              mem_din,
    input  logic                    mem_w_ready
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int BEAT_W = CNT_W + 1;

    psram_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    busy_q, busy_d;
    logic                start_q, start_d;

    logic [ADDR_W-1:0]   addrLane [N_REQ];
    logic [CNT_W-1:0]    cntLane  [N_REQ];
    logic [7:0]          wrLane   [N_REQ];

    logic [N_REQ-1:0]    rrReq, rrGrant, winGrant, idxOneHot;
    logic                rrValid, winValid, updLast;
    logic [IDX_W-1:0]    winIdx;
    logic                inXfer, activeStrobe;

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign addrLane[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign cntLane[g]  = req_cnt[g*CNT_W +: CNT_W];
        assign wrLane[g]   = wr_data[g*8 +: 8];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (rrReq),
        .last  (last_q),
        .grant (rrGrant),
        .valid (rrValid)
    );

`ifdef PSRAM_ARB_PRIO0_EN
    // Requester 0 (record channel) bypasses the rotation and leaves the pointer alone.
    assign rrReq    = {req[N_REQ-1:1], 1'b0};
    assign winGrant = req[0] ? {{(N_REQ-1){1'b0}}, 1'b1} : rrGrant;
    assign winValid = req[0] | rrValid;
    assign updLast  = ~req[0];
`else
    assign rrReq    = req;
    assign winGrant = rrGrant;
    assign winValid = rrValid;
    assign updLast  = 1'b1;
`endif

    // Turn the one-hot winner into an index for latching and steering.
    always_comb begin
        winIdx = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (winGrant[j]) winIdx = IDX_W'(j);
        end
    end

    assign inXfer       = (state_q == XFER);
    assign activeStrobe = we_q ? mem_w_ready : mem_r_valid;
    assign idxOneHot    = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;

    assign rd_data         = inXfer ? mem_dout : 8'h00;
    assign rd_valid        = (inXfer && mem_r_valid) ? idxOneHot : '0;
    assign wr_ready        = (inXfer && mem_w_ready) ? idxOneHot : '0;
    assign mem_din         = inXfer ? wrLane[idx_q] : 8'h00;
    assign mem_start_read  = start_q & ~we_q;
    assign mem_start_write = start_q & we_q;
    assign mem_addr        = addr_q;
    assign mem_count       = cnt_q;
    assign ack             = ack_q;
    assign busy            = busy_q;

    // Next-state logic: grant in IDLE, kick the controller in START, count beats in XFER.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        ack_d   = '0;
        busy_d  = busy_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (winValid) begin
                    idx_d   = winIdx;
                    we_d    = req_we[winIdx];
                    addr_d  = addrLane[winIdx];
                    cnt_d   = cntLane[winIdx];
                    ack_d   = winGrant;
                    busy_d  = winGrant;
                    if (updLast) last_d = winIdx;
                    state_d = START;
                end
            end
            START: begin
                beats_d = (cnt_q == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, cnt_q};
                start_d = 1'b1;
                state_d = XFER;
            end
            XFER: begin
                if (activeStrobe) begin
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) begin
                        busy_d  = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            beats_q <= '0;
            ack_q   <= '0;
            busy_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: expected grants and controller commands
// are queued when requests are raised and popped by a monitor when they appear.
module tb_psram_arbiter;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int CW = 9;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [CW-1:0] cnt;
    } cmd_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    reqWe;
    logic [N*AW-1:0] reqAddr;
    logic [N*CW-1:0] reqCnt;
    logic [N-1:0]    ack;
    logic [N-1:0]    busy;
    logic [7:0]      rdData;
    logic [N-1:0]    rdValid;
    logic [N*8-1:0]  wrData;
    logic [N-1:0]    wrReady;
    logic            memStartRead;
    logic            memStartWrite;
    logic [CW-1:0]   memCount;
    logic [AW-1:0]   memAddr;
    logic [7:0]      memDout;
    logic            memRValid;
    logic [7:0]      memDin;
    logic            memWReady;

    int   checks = 0;
    int   errors = 0;
    int   grantQ[$];
    cmd_t cmdQ[$];
    int   monIdx;
    cmd_t monCmd;
    int   cyc;
    int   expIdx[2];

    psram_arbiter #(.N_REQ(N), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_we          (reqWe),
        .req_addr        (reqAddr),
        .req_cnt         (reqCnt),
        .ack             (ack),
        .busy            (busy),
        .rd_data         (rdData),
        .rd_valid        (rdValid),
        .wr_data         (wrData),
        .wr_ready        (wrReady),
        .mem_start_read  (memStartRead),
        .mem_start_write (memStartWrite),
        .mem_count       (memCount),
        .mem_addr        (memAddr),
        .mem_dout        (memDout),
        .mem_r_valid     (memRValid),
        .mem_din         (memDin),
        .mem_w_ready     (memWReady)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectBurst(input int idx, input logic we, input logic [AW-1:0] addr, input logic [CW-1:0] cnt);
        cmd_t c;
        c.we   = we;
        c.addr = addr;
        c.cnt  = cnt;
        grantQ.push_back(idx);
        cmdQ.push_back(c);
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic [AW-1:0] addr, input logic [CW-1:0] cnt);
        reqAddr[idx*AW +: AW] = addr;
        reqCnt[idx*CW +: CW]  = cnt;
        reqWe[idx]            = we;
        req[idx]              = 1'b1;
    endtask

    // Wait for the controller kick; requesters in dropMask release req once acked.
    task automatic waitStart(input logic [N-1:0] dropMask, output int cycles);
        bit started = 1'b0;
        cycles = 0;
        while (!started && cycles < 40) begin
            @(negedge clk);
            cycles++;
            req = req & ~(ack & dropMask);
            if (memStartRead || memStartWrite) started = 1'b1;
        end
        if (!started) checkOutput("start_timeout", 32'd0, 32'd1);
    endtask

    // Strobe the active direction n times, then strobe once more in GAP.
    task automatic strobeBeats(input int n, input logic we, input int idx, input logic [7:0] base);
        logic [N-1:0] oh;
        int           good;
        bit           ok;
        oh   = N'(1) << idx;
        good = 0;
        for (int i = 0; i < n; i++) begin
            if (we) memWReady = 1'b1;
            else begin
                memRValid = 1'b1;
                memDout   = base + 8'(i);
            end
            #1;
            if (we) ok = (wrReady === oh) && (rdValid === '0) && (memDin === wrData[idx*8 +: 8]);
            else    ok = (rdValid === oh) && (wrReady === '0) && (rdData === memDout);
            ok = ok && (busy === oh) && (i == 0 || (memStartRead | memStartWrite) === 1'b0);
            good += int'(ok);
            @(negedge clk);
        end
        checkOutput("beat_count", 32'(good), 32'(n));
        #1;
        checkOutput("gap_route", {24'd0, rdValid, wrReady}, 32'd0);
        checkOutput("gap_busy", 32'(busy), 32'd0);
        memRValid = 1'b0;
        memWReady = 1'b0;
    endtask

    // Scoreboard monitor: grants and controller commands in the queued order.
    always @(negedge clk) begin
        if (ack !== '0) begin
            if (grantQ.size() == 0) checkOutput("ack_unexpected", 32'(ack), 32'd0);
            else begin
                monIdx = grantQ.pop_front();
                checkOutput("ack_order", 32'(ack), 32'(1) << monIdx);
            end
        end
        if (memStartRead || memStartWrite) begin
            if (cmdQ.size() == 0) checkOutput("start_unexpected", 32'd1, 32'd0);
            else begin
                monCmd = cmdQ.pop_front();
                checkOutput("start_dir", {30'd0, memStartRead, memStartWrite}, monCmd.we ? 32'd1 : 32'd2);
                checkOutput("start_addr", 32'(memAddr), 32'(monCmd.addr));
                checkOutput("start_cnt", 32'(memCount), 32'(monCmd.cnt));
            end
        end
    end

    initial begin
        req       = '0;
        reqWe     = '0;
        reqAddr   = '0;
        reqCnt    = '0;
        wrData    = {8'h33, 8'h22, 8'h11, 8'h00};
        memDout   = 8'h5A;
        memRValid = 1'b1;
        memWReady = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        // Reset state: everything quiet even though the controller strobes.
        @(negedge clk);
        #1;
        checkOutput("rst_ack_busy", {24'd0, ack, busy}, 32'd0);
        checkOutput("rst_routes", {24'd0, rdValid, wrReady}, 32'd0);
        checkOutput("rst_start", {30'd0, memStartRead, memStartWrite}, 32'd0);
        checkOutput("rst_addr", 32'(memAddr), 32'd0);
        checkOutput("rst_cnt", 32'(memCount), 32'd0);
        checkOutput("rst_data", {16'd0, rdData, memDin}, 32'd0);
        memRValid = 1'b0;
        memWReady = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Read burst of 4 on requester 2.
        expectBurst(2, 1'b0, 23'h000100, 9'd4);
        applyStimulus(2, 1'b0, 23'h000100, 9'd4);
        waitStart(4'b0100, cyc);
        checkOutput("first_latency", 32'(cyc), 32'd2);
        strobeBeats(4, 1'b0, 2, 8'h10);

        // Requesters 0 and 1 held high alternate with one gap between bursts.
        expectBurst(0, 1'b0, 23'h000200, 9'd2);
        expectBurst(1, 1'b0, 23'h000300, 9'd2);
        expectBurst(0, 1'b0, 23'h000200, 9'd2);
        expectBurst(1, 1'b0, 23'h000300, 9'd2);
        applyStimulus(0, 1'b0, 23'h000200, 9'd2);
        applyStimulus(1, 1'b0, 23'h000300, 9'd2);
        for (int b = 0; b < 4; b++) begin
            waitStart('0, cyc);
            checkOutput("regrant_gap", 32'(cyc), 32'd3);
            strobeBeats(2, 1'b0, b % 2, 8'(8'h20 + b * 4));
        end
        req = '0;

        // Write burst of 3 on requester 1.
        wrData[15:8] = 8'hA5;
        expectBurst(1, 1'b1, 23'h004000, 9'd3);
        applyStimulus(1, 1'b1, 23'h004000, 9'd3);
        waitStart(4'b0010, cyc);
        strobeBeats(3, 1'b1, 1, 8'h00);

        // Count field 0 means 512 beats; the extra strobe in GAP is dropped.
        expectBurst(3, 1'b0, 23'h7FFF00, 9'd0);
        applyStimulus(3, 1'b0, 23'h7FFF00, 9'd0);
        waitStart(4'b1000, cyc);
        strobeBeats(512, 1'b0, 3, 8'h80);

        // Reset mid-burst after 2 of 8 beats.
        expectBurst(2, 1'b0, 23'h000005, 9'd8);
        applyStimulus(2, 1'b0, 23'h000005, 9'd8);
        waitStart(4'b0100, cyc);
        memRValid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("pre_reset_route", 32'(rdValid), 32'h4);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ack_busy", {24'd0, ack, busy}, 32'd0);
        checkOutput("midrst_routes", {24'd0, rdValid, wrReady}, 32'd0);
        checkOutput("midrst_start", {30'd0, memStartRead, memStartWrite}, 32'd0);
        checkOutput("midrst_addr_cnt", {memAddr, memCount}, 32'd0);
        checkOutput("midrst_data", {16'd0, rdData, memDin}, 32'd0);
        memRValid = 1'b0;

        // After reset the pointer restarts, so requester 0 beats requester 3.
`ifdef PSRAM_ARB_PRIO0_EN
        expIdx = '{0, 0};
`else
        expIdx = '{0, 3};
`endif
        for (int b = 0; b < 2; b++) begin
            expectBurst(expIdx[b], 1'b0, (expIdx[b] == 0) ? 23'h000010 : 23'h300000, 9'd1);
        end
        @(negedge clk);
        applyStimulus(0, 1'b0, 23'h000010, 9'd1);
        applyStimulus(3, 1'b0, 23'h300000, 9'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 2; b++) begin
            waitStart('0, cyc);
            strobeBeats(1, 1'b0, expIdx[b], 8'h40);
        end
        req = '0;

        repeat (4) @(negedge clk);
        checkOutput("final_busy", 32'(busy), 32'd0);
        checkOutput("grantq_empty", 32'(grantQ.size()), 32'd0);
        checkOutput("cmdq_empty", 32'(cmdQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single PSRAM controller between N_REQ burst requesters, e.g. track playback readers and the record writer.
- Arbitrates round-robin and issues one start_read/start_write burst per grant to the controller.
- Steers controller read data and write-ready beats to the granted requester.
- Counts beats locally, because the controller has no done signal, and enforces one idle gap cycle between bursts so CE# is deasserted.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 23, PSRAM byte address width.
- CNT_W, 9, burst length field width; value 0 encodes 512 bytes.

Ports:
- clk  in  1  system clock (100 MHz, same as the PSRAM controller).
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  request level per requester.
- req_we  in  N_REQ  1 = write burst, 0 = read burst.
- req_addr  in  N_REQ*ADDR_W  packed start addresses.
- req_cnt  in  N_REQ*CNT_W  packed burst lengths.
- ack  out  N_REQ  one-cycle grant pulse.
- busy  out  N_REQ  high while that requester's burst is in flight.
- rd_data  out  8  read byte, broadcast to all requesters.
- rd_valid  out  N_REQ  read strobe, routed to the granted requester only.
- wr_data  in  N_REQ*8  packed write bytes.
- wr_ready  out  N_REQ  write-consume strobe, routed to the granted requester only.
- mem_start_read  out  1  to controller start_read.
- mem_start_write  out  1  to controller start_write.
- mem_count  out  CNT_W  to controller count.
- mem_addr  out  ADDR_W  to controller address_in.
- mem_dout  in  8  from controller dout.
- mem_r_valid  in  1  from controller r_valid.
- mem_din  out  8  to controller din.
- mem_w_ready  in  1  from controller w_ready.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 wins first.
  - Beat counter 0.
  - Reset mid-burst abandons the burst with no completion signalling; the controller is reset by the same net.
- Request rule: requester holds req, req_we, req_addr and req_cnt stable until it sees ack. The arbiter latches all fields at grant. Changes after ack are ignored until the next arbitration.
- States IDLE -> START -> XFER -> GAP -> IDLE:
  - IDLE: if any req bit is set, the winner is the first set bit searching last+1, last+2, ... (mod N_REQ). On that edge: register winner idx, latch fields, pulse ack[idx], set busy[idx], last <= idx, go to START. If no req, stay in IDLE.
  - START: one-cycle pulse on mem_start_read or mem_start_write, per the latched we. mem_addr and mem_count are driven from the latched fields and hold through XFER. Load beats = (cnt==0) ? 512 : cnt (10-bit). Go to XFER.
  - XFER: rd_data = mem_dout combinationally; rd_valid[idx] = mem_r_valid; mem_din = wr_data[idx]; wr_ready[idx] = mem_w_ready. Each strobe of the active direction decrements beats. When beats==1 and a strobe occurs, go to GAP. Strobes in the inactive direction are ignored.
  - GAP: clear busy[idx]; no routing (all rd_valid and wr_ready are 0). Go to IDLE.
- Latency:
  - req sampled high on edge k → ack high cycle k..k+1.
  - mem_start pulse on the next cycle.
  - Minimum re-grant: 1 cycle after GAP.
- Fairness: a requester that keeps req high after its burst is served again only after every other pending requester has been served.
- Simultaneous requests: resolved purely by the pointer; no starvation.
- Outside XFER: rd_valid and wr_ready are forced 0 even if the controller strobes.

Optional Feature:
- Macro: PSRAM_ARB_PRIO0_EN.
- Defined: requester 0 is fixed highest priority. If req[0] is set in IDLE, requester 0 wins regardless of the pointer, and the pointer is not updated by a requester-0 grant. Other requesters remain round-robin among themselves. Intended for the record channel, which must not overflow.
- Undefined: pure round-robin over all N_REQ requesters.

Decomposition:
- Shared package psram_pkg:
  - PSRAM_ADDR_W=23 and PSRAM_CNT_W=9.
  - State enum typedef psram_arb_state_t {IDLE, START, XFER, GAP}.
  - Command constants CMD_FAST_READ=8'h0B and CMD_WRITE=8'h02, shared with the controller.
- Sub-module rr_arbiter: combinational rotating priority encoder. Inputs req and last; outputs a one-hot grant and a valid bit. Parameterised by N_REQ; reused by the future DMA scheduler.

Test Plan:
- Reset, then req[2]=1, we=0, addr=0x000100, cnt=4. Expect ack[2] one cycle later, then mem_start_read for one cycle with mem_addr=0x000100 and mem_count=4. Four mem_r_valid pulses appear on rd_valid[2] only. busy[2] falls in GAP.
- req[0] and req[1] held high, each cnt=2. Grants alternate 0,1,0,1. Exactly one idle GAP cycle separates bursts.
- Write burst on req[1], cnt=3, wr_data[1]=0xA5. mem_din=0xA5 during XFER; wr_ready[1] pulses 3 times; other wr_ready bits stay 0.
- cnt=0 burst. Exactly 512 strobes are counted before GAP; the 513th controller strobe (injected) is not routed.
- Assert rst_n=0 mid-XFER after 2 of 8 beats. All outputs go to 0 asynchronously. After release, req[0] is granted first.
- With PSRAM_ARB_PRIO0_EN defined, and req[0], req[3] both pending with last=3: requester 0 is granted on every arbitration while req[0] stays high. Without the macro, requester 3 follows requester 0.
